// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding and
// small decode helpers used by the top level.
// Latency / backpressure: not applicable (declarations only).
package alu_pkg;

  // Opcode map. The low two bits of suma/resta/shift_d/shift_i keep the
  // legacy 2-bit ALU encoding (00 suma, 01 shift_d, 10 resta, 11 shift_i),
  // so existing decoders that look only at bits [1:0] stay valid for those ops.
  typedef enum logic [2:0] {
    OP_SUMA    = 3'b000,
    OP_SHIFT_D = 3'b001,
    OP_RESTA   = 3'b010,
    OP_SHIFT_I = 3'b011,
    OP_MULT    = 3'b100,
    OP_AND     = 3'b101,
    OP_OR      = 3'b110,
    OP_XOR     = 3'b111
  } opcode_t;

  // Legacy 2-bit ALU encoding, kept for reference by older blocks.
  localparam logic [1:0] ALU2_SUMA    = 2'b00;
  localparam logic [1:0] ALU2_SHIFT_D = 2'b01;
  localparam logic [1:0] ALU2_RESTA   = 2'b10;
  localparam logic [1:0] ALU2_SHIFT_I = 2'b11;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_t;

  // True for the two single-bit-per-cycle shift operations.
  function automatic logic is_shift(input opcode_t op);
    return (op == OP_SHIFT_D) || (op == OP_SHIFT_I);
  endfunction

  // True for operations that finish without any iteration.
  function automatic logic is_single_cycle(input opcode_t op);
    return (op == OP_SUMA) || (op == OP_RESTA) ||
           (op == OP_AND)  || (op == OP_OR)    || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_mult_seq.sv
// Shift-add multiplier datapath, one partial product per step.
// Latency: N steps after load; the parent FSM issues the steps.
// Backpressure: none; it only moves when load/step are asserted.
//
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high clear
//   load     capture A (multiplicand) and B (multiplier), clear accumulator
//   step     add multiplicand if multiplier LSB set, then shift both
//   A, B     N-bit unsigned operands
//   product  2N-bit accumulated product (complete after N steps)
module alu_mult_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] product
);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;   // multiplicand, moves left one place per step
  logic [N-1:0]   mplier;  // multiplier, consumed from the LSB

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{N{1'b0}}, A};
      mplier <= B;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_secuencial.sv
// Sequential ALU: add/sub/logic in one pass, shifts 1 bit/cycle, shift-add multiply.
// Latency: done pulses iterations+1 cycles after accept (0 / k / N iterations).
// Backpressure: i_start is accepted only while busy is low; ignored otherwise.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset, aborts any operation
//   i_a, i_b   N-bit unsigned operands (i_b[W-1:0] is the shift amount)
//   i_control  3-bit opcode (see alu_pkg::opcode_t)
//   i_start    request, accepted when high and busy is low
//   busy       operation in progress (accept+1 through the done cycle)
//   done       one-cycle pulse, q/mayor/cero valid
//   q          registered result
//   mayor      registered carry/borrow/overflow/shift-out flag
//   cero       registered q == 0 flag
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_control,
  input  logic         i_start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic         mayor,
  output logic         cero
);

  localparam int W = $clog2(N);

  state_t         state;
  state_t         state_nxt;
  opcode_t        op_r;
  opcode_t        op_in;
  logic [N-1:0]   a_r;        // operand A; doubles as the shift register
  logic [N-1:0]   b_r;
  logic           sh_out;     // last bit shifted out of a_r
  logic [W:0]     cnt;        // shared iteration counter, holds up to N
  logic [W:0]     cnt_init;
  logic           accept;
  logic           step_en;
  logic           mult_step;
  logic           finish;
  logic [2*N-1:0] product;
  logic [N:0]     sum_ext;
  logic [N:0]     dif_ext;
  logic [N-1:0]   res_q;
  logic           res_m;

  assign op_in     = opcode_t'(i_control);
  assign accept    = i_start && (state == IDLE);
  assign step_en   = (state == CALC) && (cnt != '0);
  assign mult_step = step_en && (op_r == OP_MULT);
  // The last CALC cycle: every iteration has been applied, result is ready.
  assign finish    = (state == CALC) && (cnt == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = CALC;
      CALC:    if (cnt == '0)   state_nxt = FIN;
      FIN:                      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. FIN is the done cycle and still counts as busy, which is
  // what keeps a start request in that cycle from being accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // ---------------------------------------------------------------------------
  // Iteration count loaded on accept: 0 for one-pass ops, k for shifts, N for
  // multiply.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_init = '0;
    if (is_shift(op_in)) begin
      cnt_init = {1'b0, i_b[W-1:0]};
    end else if (op_in == OP_MULT) begin
      cnt_init = (W+1)'(N);
    end else if (is_single_cycle(op_in)) begin
      cnt_init = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture, shifting and counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_r   <= OP_SUMA;
      a_r    <= '0;
      b_r    <= '0;
      sh_out <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      op_r   <= op_in;
      a_r    <= i_a;
      b_r    <= i_b;
      sh_out <= 1'b0;          // a zero-length shift reports no shifted-out bit
      cnt    <= cnt_init;
    end else if (step_en) begin
      cnt <= cnt - (W+1)'(1);
      if (op_r == OP_SHIFT_D) begin
        sh_out <= a_r[0];
        a_r    <= a_r >> 1;
      end else if (op_r == OP_SHIFT_I) begin
        sh_out <= a_r[N-1];
        a_r    <= a_r << 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier datapath, stepped only while a multiply is iterating.
  // ---------------------------------------------------------------------------
  alu_mult_seq #(
    .N (N)
  ) u_mult (
    .clk     (i_clk),
    .reset   (i_reset),
    .load    (accept),
    .step    (mult_step),
    .A       (i_a),
    .B       (i_b),
    .product (product)
  );

  // ---------------------------------------------------------------------------
  // Result selection from the latched operands / iterated state.
  // The extra top bit of sum_ext is the carry; of dif_ext it is the borrow
  // (set exactly when A < B).
  // ---------------------------------------------------------------------------
  assign sum_ext = {1'b0, a_r} + {1'b0, b_r};
  assign dif_ext = {1'b0, a_r} - {1'b0, b_r};

  always_comb begin
    res_q = '0;
    res_m = 1'b0;
    case (op_r)
      OP_SUMA: begin
        res_q = sum_ext[N-1:0];
        res_m = sum_ext[N];
      end
      OP_RESTA: begin
        res_q = dif_ext[N-1:0];
        res_m = dif_ext[N];
      end
      OP_SHIFT_D, OP_SHIFT_I: begin
        res_q = a_r;
        res_m = sh_out;
      end
      OP_MULT: begin
        res_q = product[N-1:0];
        res_m = |product[2*N-1:N];
      end
      OP_AND:  res_q = a_r & b_r;
      OP_OR:   res_q = a_r | b_r;
      OP_XOR:  res_q = a_r ^ b_r;
      default: begin
        res_q = '0;
        res_m = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result registers: written only on the CALC->FIN edge so they hold from one
  // done pulse to the next.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q     <= '0;
      mayor <= 1'b0;
      cero  <= 1'b1;
    end else if (finish) begin
      q     <= res_q;
      mayor <= res_m;
      cero  <= (res_q == '0);
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
module tb_alu_secuencial;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic [2:0]  i_control;
  logic        i_start;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic        mayor;
  logic        cero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  alu_secuencial #(.N(16)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_control (i_control),
    .i_start   (i_start),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .mayor     (mayor),
    .cero      (cero)
  );

  // Reference model: expected result, flag and accept-to-done latency,
  // computed with plain integer arithmetic on 16-bit operands.
  function automatic void model(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] eq, output logic em, output int elat);
    logic [31:0] w;
    int k;
    k    = int'(b[3:0]);
    elat = 1;
    em   = 1'b0;
    eq   = 16'h0;
    case (c)
      3'b000: begin w = {16'h0, a} + {16'h0, b}; eq = w[15:0]; em = w[16]; end
      3'b010: begin eq = a - b; em = (a < b); end
      3'b001: begin
        eq = a >> k; elat = k + 1;
        if (k != 0) em = a[k-1];
      end
      3'b011: begin
        eq = a << k; elat = k + 1;
        if (k != 0) em = a[16-k];
      end
      3'b100: begin w = {16'h0, a} * {16'h0, b}; eq = w[15:0]; em = (w[31:16] != 16'h0); elat = 17; end
      3'b101: eq = a & b;
      3'b110: eq = a | b;
      default: eq = a ^ b;
    endcase
  endfunction

  // Issues one operation (called #1 after an edge with busy low), scrambles the
  // inputs while busy, and returns what the DUT showed at done plus one cycle later.
  task automatic run_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [15:0] oq, output logic om, output logic oc,
                        output logic busy_at_done, output logic done_after);
    i_control = c; i_a = a; i_b = b; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_a = 16'($urandom); i_b = 16'($urandom); i_control = 3'($urandom);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    oq = q; om = mayor; oc = cero; busy_at_done = busy;
    @(posedge i_clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b1; i_a = 16'h1234; i_b = 16'h0001; i_control = 3'b000;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if ({busy, done, q, mayor, cero} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b q=%h mayor=%b cero=%b, expected 0 0 0000 0 1",
               busy, done, q, mayor, cero);
    end
    i_start = 1'b0;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  tc [12];
    logic [15:0] ta [12];
    logic [15:0] tb [12];
    logic [15:0] xq [12];
    logic        xm [12];
    int          xl [12];
    int lat; logic [15:0] oq; logic om, oc, bd, da;
    tc[0]  = 3'b000; ta[0]  = 16'hFFFF; tb[0]  = 16'h0001; xq[0]  = 16'h0000; xm[0]  = 1; xl[0]  = 1;
    tc[1]  = 3'b010; ta[1]  = 16'h0003; tb[1]  = 16'h0005; xq[1]  = 16'hFFFE; xm[1]  = 1; xl[1]  = 1;
    tc[2]  = 3'b010; ta[2]  = 16'h0005; tb[2]  = 16'h0003; xq[2]  = 16'h0002; xm[2]  = 0; xl[2]  = 1;
    tc[3]  = 3'b011; ta[3]  = 16'h1001; tb[3]  = 16'h0004; xq[3]  = 16'h0010; xm[3]  = 1; xl[3]  = 5;
    tc[4]  = 3'b001; ta[4]  = 16'hABCD; tb[4]  = 16'h0000; xq[4]  = 16'hABCD; xm[4]  = 0; xl[4]  = 1;
    tc[5]  = 3'b100; ta[5]  = 16'h00FF; tb[5]  = 16'h0003; xq[5]  = 16'h02FD; xm[5]  = 0; xl[5]  = 17;
    tc[6]  = 3'b100; ta[6]  = 16'h0100; tb[6]  = 16'h0100; xq[6]  = 16'h0000; xm[6]  = 1; xl[6]  = 17;
    tc[7]  = 3'b101; ta[7]  = 16'hF0F0; tb[7]  = 16'h3C3C; xq[7]  = 16'h3030; xm[7]  = 0; xl[7]  = 1;
    tc[8]  = 3'b110; ta[8]  = 16'hF0F0; tb[8]  = 16'h3C3C; xq[8]  = 16'hFCFC; xm[8]  = 0; xl[8]  = 1;
    tc[9]  = 3'b111; ta[9]  = 16'hF0F0; tb[9]  = 16'h3C3C; xq[9]  = 16'hCCCC; xm[9]  = 0; xl[9]  = 1;
    tc[10] = 3'b001; ta[10] = 16'hC000; tb[10] = 16'hFFFF; xq[10] = 16'h0001; xm[10] = 1; xl[10] = 16;
    tc[11] = 3'b000; ta[11] = 16'h1234; tb[11] = 16'h4321; xq[11] = 16'h5555; xm[11] = 0; xl[11] = 1;
    for (int i = 0; i < 12; i++) begin
      run_op(tc[i], ta[i], tb[i], lat, oq, om, oc, bd, da);
      n_checks++;
      if (lat !== xl[i] || oq !== xq[i] || om !== xm[i] || oc !== (xq[i] == 16'h0)) begin
        n_fail++;
        $display("FAIL directed[%0d]: lat=%0d q=%h mayor=%b cero=%b, expected lat=%0d q=%h mayor=%b cero=%b",
                 i, lat, oq, om, oc, xl[i], xq[i], xm[i], (xq[i] == 16'h0));
      end
      n_checks++;
      if (bd !== 1'b1 || da !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_pulse[%0d]: busy_at_done=%b done_next=%b, expected 1 0", i, bd, da);
      end
    end
  endtask

  task automatic test_random();
    int lat, elat; logic [15:0] oq, eq, a, b; logic om, oc, bd, da, em; logic [2:0] c;
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b = 16'($urandom);
      model(c, a, b, eq, em, elat);
      run_op(c, a, b, lat, oq, om, oc, bd, da);
      n_checks++;
      if (lat !== elat || oq !== eq || om !== em || oc !== (eq == 16'h0) || da !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: lat=%0d q=%h mayor=%b cero=%b done_next=%b, expected lat=%0d q=%h mayor=%b cero=%b done_next=0",
                 i, c, a, b, lat, oq, om, oc, da, elat, eq, em, (eq == 16'h0));
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    i_control = 3'b100; i_a = 16'h00FF; i_b = 16'h0003; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
      if (lat == 5) begin
        i_start = 1'b1; i_a = 16'h1234; i_b = 16'h0002; i_control = 3'b000;
      end else if (lat == 6) begin
        i_start = 1'b0;
      end
    end
    n_checks++;
    if (lat !== 17 || q !== 16'h02FD || mayor !== 1'b0 || cero !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: lat=%0d q=%h mayor=%b cero=%b, expected lat=17 q=02fd mayor=0 cero=0",
               lat, q, mayor, cero);
    end
    // Request during the done cycle must also be ignored.
    i_start = 1'b1; i_control = 3'b100; i_a = 16'h0005; i_b = 16'h0005;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 16'h02FD) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b done=%b q=%h, expected 0 0 02fd", busy, done, q);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    i_control = 3'b100; i_a = 16'h1234; i_b = 16'h5678; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (7) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    n_checks++;
    if ({busy, done, q, mayor, cero} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b q=%h mayor=%b cero=%b, expected 0 0 0000 0 1",
               busy, done, q, mayor, cero);
    end
    dones = 0;
    repeat (25) begin
      @(posedge i_clk); #1;
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulses=%0d, expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  c [2];
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [15:0] eq; logic em; int elat;
    int first, last, cnt, bad, exp_cnt, waitc;
    c[0] = 3'b011; a[0] = 16'h1001; b[0] = 16'h0004;
    c[1] = 3'b000; a[1] = 16'hFFFF; b[1] = 16'h0001;
    for (int t = 0; t < 2; t++) begin
      model(c[t], a[t], b[t], eq, em, elat);
      i_control = c[t]; i_a = a[t]; i_b = b[t]; i_start = 1'b1;
      first = -1; last = -1; cnt = 0; bad = 0;
      for (int e = 1; e <= 40; e++) begin
        @(posedge i_clk); #1;
        if (done) begin
          if (first < 0) first = e;
          else if (e - last != elat + 2) bad++;
          if (q !== eq || mayor !== em) bad++;
          last = e;
          cnt++;
        end
      end
      i_start = 1'b0;
      exp_cnt = 0;
      for (int e = elat + 1; e <= 40; e += elat + 2) exp_cnt++;
      n_checks++;
      if (first !== elat + 1 || cnt !== exp_cnt || bad !== 0) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: first=%0d count=%0d bad=%0d, expected first=%0d count=%0d bad=0",
                 t, first, cnt, bad, elat + 1, exp_cnt);
      end
      waitc = 0;
      while (busy && waitc < 50) begin
        @(posedge i_clk); #1;
        waitc++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_drain[%0d]: busy=%b, expected 0", t, busy);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_a = 16'h0; i_b = 16'h0; i_control = 3'b000;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
